// File: rtl/hazard_if.sv
// Hazard reports from the core pipeline and the stall/flush/redirect controls returned to it.
interface hazard_if #(
    parameter int unsigned CNT_W = 32
);
    logic             ic_miss;
    logic             dc_miss;
    logic             dec_uses_rs;
    logic [4:0]       dec_rs_addr;
    logic             dec_uses_rt;
    logic [4:0]       dec_rt_addr;
    logic             ex_is_load;
    logic [4:0]       ex_rw_addr;
    logic             ex_mispredict;

    logic             pc_stall;
    logic             pc_redirect;
    logic             i2d_stall;
    logic             i2d_flush;
    logic             d2e_stall;
    logic             d2e_flush;
    logic             e2m_stall;
    logic             e2m_flush;
    logic             m2w_stall;
    logic             m2w_flush;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_events;
    logic [CNT_W-1:0] load_use_events;
    logic             hang_err;

    // Core side: reports hazards, consumes controls.
    modport master (
        output ic_miss, dc_miss, dec_uses_rs, dec_rs_addr, dec_uses_rt, dec_rt_addr,
               ex_is_load, ex_rw_addr, ex_mispredict,
        input  pc_stall, pc_redirect, i2d_stall, i2d_flush, d2e_stall, d2e_flush,
               e2m_stall, e2m_flush, m2w_stall, m2w_flush,
               stall_cycles, flush_events, load_use_events, hang_err
    );

    // Controller side.
    modport slave (
        input  ic_miss, dc_miss, dec_uses_rs, dec_rs_addr, dec_uses_rt, dec_rt_addr,
               ex_is_load, ex_rw_addr, ex_mispredict,
        output pc_stall, pc_redirect, i2d_stall, i2d_flush, d2e_stall, d2e_flush,
               e2m_stall, e2m_flush, m2w_stall, m2w_flush,
               stall_cycles, flush_events, load_use_events, hang_err
    );
endinterface

// File: rtl/hazard_controller.sv
// Fixed-priority hazard resolution for the five-stage core: stall/flush pairs, PC hold/redirect,
// one-shot redirect latch, saturating perf counters and a d-miss watchdog.
module hazard_controller #(
    parameter int unsigned CNT_W        = 32,
    parameter int unsigned MISS_TIMEOUT = 1024
) (
    input logic     clk,
    input logic     rst_n,
    hazard_if.slave hz
);

    localparam int unsigned MW = $clog2(MISS_TIMEOUT + 1);
    localparam logic [MW-1:0] MISS_LAST = MW'(MISS_TIMEOUT - 1);

    typedef enum logic {
        RUN   = 1'b0,
        ARMED = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic [CNT_W-1:0] lu_cnt;
    logic [MW-1:0]    miss_run;
    logic             hang_q;

    logic load_use_c;
    logic redirect_c;
    logic lu_take_c;
    logic hang_set_c;

    // Hazard classification; $zero never carries a dependency.
    assign load_use_c = hz.ex_is_load && (hz.ex_rw_addr != 5'd0) &&
                        ((hz.dec_uses_rs && (hz.dec_rs_addr == hz.ex_rw_addr)) ||
                         (hz.dec_uses_rt && (hz.dec_rt_addr == hz.ex_rw_addr)));
    assign redirect_c = !hz.dc_miss && hz.ex_mispredict && (state == RUN);
    assign lu_take_c  = !hz.dc_miss && !redirect_c && load_use_c;
    assign hang_set_c = hz.dc_miss && (miss_run == MISS_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= RUN;
        else        state <= state_nxt;
    end

    // Next state: ARMED suppresses re-firing until the branch leaves EX
    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (redirect_c)        state_nxt = ARMED;
            ARMED:   if (!hz.ex_mispredict) state_nxt = RUN;
            default:                        state_nxt = RUN;
        endcase
    end

    // Output decode, highest priority first
    always_comb begin
        hz.pc_stall    = 1'b0;
        hz.pc_redirect = 1'b0;
        hz.i2d_stall   = 1'b0;
        hz.i2d_flush   = 1'b0;
        hz.d2e_stall   = 1'b0;
        hz.d2e_flush   = 1'b0;
        hz.e2m_stall   = 1'b0;
        hz.e2m_flush   = 1'b0;
        hz.m2w_stall   = 1'b0;
        hz.m2w_flush   = 1'b0;
        if (hz.dc_miss) begin
            hz.pc_stall  = 1'b1;
            hz.i2d_stall = 1'b1;
            hz.d2e_stall = 1'b1;
            hz.e2m_stall = 1'b1;
            hz.m2w_flush = 1'b1;
        end else if (redirect_c) begin
            hz.pc_redirect = 1'b1;
            hz.i2d_flush   = 1'b1;
            hz.d2e_flush   = 1'b1;
        end else if (lu_take_c) begin
            hz.pc_stall  = 1'b1;
            hz.i2d_stall = 1'b1;
            hz.d2e_flush = 1'b1;
        end else if (hz.ic_miss) begin
            hz.pc_stall  = 1'b1;
            hz.i2d_flush = 1'b1;
        end
    end

    // Saturating perf counters and d-miss watchdog
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
            lu_cnt    <= '0;
            miss_run  <= '0;
            hang_q    <= 1'b0;
        end else begin
            if (hz.pc_stall && (stall_cnt != '1))    stall_cnt <= stall_cnt + CNT_W'(1);
            if (hz.pc_redirect && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
            if (lu_take_c && (lu_cnt != '1))         lu_cnt    <= lu_cnt + CNT_W'(1);
            if (!hz.dc_miss)                         miss_run  <= '0;
            else if (miss_run != '1)                 miss_run  <= miss_run + MW'(1);
            if (hang_set_c)                          hang_q    <= 1'b1;
        end
    end

    assign hz.stall_cycles    = stall_cnt;
    assign hz.flush_events    = flush_cnt;
    assign hz.load_use_events = lu_cnt;
    assign hz.hang_err        = hang_q | hang_set_c;

endmodule

// File: tb/tb_hazard_controller.sv
// Scoreboard bench for hazard_controller: directed scenarios plus randomized traffic vs a reference model.
module tb_hazard_controller;

    localparam int CW      = 8;
    localparam int SAT     = 255;
    localparam int TIMEOUT = 4;

    typedef struct packed {
        logic       ic;
        logic       dc;
        logic       urs;
        logic [4:0] rs;
        logic       urt;
        logic [4:0] rt;
        logic       ld;
        logic [4:0] rw;
        logic       mp;
    } stim_t;

    typedef struct packed {
        logic [9:0]    ctl;
        logic [CW-1:0] sc;
        logic [CW-1:0] fe;
        logic [CW-1:0] lu;
        logic          hang;
    } exp_t;

    logic clk;
    logic rst_n;

    hazard_if #(.CNT_W(CW)) hz ();

    hazard_controller #(.CNT_W(CW), .MISS_TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model state: whether the current branch in EX already redirected
    bit m_redirected;
    int m_stalls, m_flushes, m_loaduse, m_miss_len;
    bit m_hang;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, want, $time);
        end
    endtask

    task automatic apply(input stim_t s);
        hz.ic_miss       = s.ic;
        hz.dc_miss       = s.dc;
        hz.dec_uses_rs   = s.urs;
        hz.dec_rs_addr   = s.rs;
        hz.dec_uses_rt   = s.urt;
        hz.dec_rt_addr   = s.rt;
        hz.ex_is_load    = s.ld;
        hz.ex_rw_addr    = s.rw;
        hz.ex_mispredict = s.mp;
    endtask

    function automatic stim_t rand_stim();
        stim_t s;
        s.ic  = ($urandom_range(0, 3) == 0);
        s.dc  = ($urandom_range(0, 5) == 0);
        s.urs = 1'($urandom_range(0, 1));
        s.rs  = 5'($urandom_range(0, 3));
        s.urt = 1'($urandom_range(0, 1));
        s.rt  = 5'($urandom_range(0, 3));
        s.ld  = 1'($urandom_range(0, 1));
        s.rw  = 5'($urandom_range(0, 3));
        s.mp  = 1'b0;
        return s;
    endfunction

    function automatic int sat_inc(input int v, input bit en);
        return (en && v < SAT) ? v + 1 : v;
    endfunction

    // One cycle: drive inputs, predict this cycle's response, advance the model
    task automatic step(input stim_t s);
        exp_t e;
        bit pcs = 0, red = 0, i2s = 0, i2f = 0, d2s = 0, d2f = 0, e2s = 0, m2f = 0;
        bit dep, lu_taken = 0;
        @(posedge clk);
        #1;
        apply(s);
        dep = s.ld && (s.rw != 0) && ((s.urs && s.rs == s.rw) || (s.urt && s.rt == s.rw));
        if (s.dc) begin
            pcs = 1; i2s = 1; d2s = 1; e2s = 1; m2f = 1;
        end else if (s.mp && !m_redirected) begin
            red = 1; i2f = 1; d2f = 1;
        end else if (dep) begin
            pcs = 1; i2s = 1; d2f = 1; lu_taken = 1;
        end else if (s.ic) begin
            pcs = 1; i2f = 1;
        end
        e.ctl  = {pcs, red, i2s, i2f, d2s, d2f, e2s, 1'b0, 1'b0, m2f};
        e.sc   = CW'(m_stalls);
        e.fe   = CW'(m_flushes);
        e.lu   = CW'(m_loaduse);
        e.hang = m_hang || (s.dc && m_miss_len == TIMEOUT - 1);
        q.push_back(e);
        m_stalls   = sat_inc(m_stalls, pcs);
        m_flushes  = sat_inc(m_flushes, red);
        m_loaduse  = sat_inc(m_loaduse, lu_taken);
        m_hang     = e.hang;
        m_miss_len = s.dc ? m_miss_len + 1 : 0;
        if (red)        m_redirected = 1;
        else if (!s.mp) m_redirected = 0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        apply(rand_stim());
        hz.ex_mispredict = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
        apply(rand_stim());
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        apply('0);
        m_redirected = 0; m_stalls = 0; m_flushes = 0; m_loaduse = 0;
        m_miss_len = 0; m_hang = 0;
    endtask

    // Monitor: compare the DUT response against the oldest prediction
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("ctl", 32'({hz.pc_stall, hz.pc_redirect, hz.i2d_stall, hz.i2d_flush,
                                hz.d2e_stall, hz.d2e_flush, hz.e2m_stall, hz.e2m_flush,
                                hz.m2w_stall, hz.m2w_flush}), 32'(e.ctl));
                chk("stall_cycles", 32'(hz.stall_cycles), 32'(e.sc));
                chk("flush_events", 32'(hz.flush_events), 32'(e.fe));
                chk("load_use_events", 32'(hz.load_use_events), 32'(e.lu));
                chk("hang_err", 32'(hz.hang_err), 32'(e.hang));
            end
        end
    end

    initial begin
        stim_t s;
        bit    mp_hold;
        int    wait_cycles;
        rst_n = 1'b0;
        apply('0);

        do_reset();
        step('0);

        // load-use on rt, then the $zero variant
        s = '0; s.ld = 1; s.rw = 5'd8; s.urt = 1; s.rt = 5'd8;
        step(s);
        step('0);
        s.rw = 5'd0; s.rt = 5'd0;
        step(s);
        step('0);

        // mispredict held three cycles: a single redirect
        s = '0; s.mp = 1;
        repeat (3) step(s);
        step('0);

        // mispredict behind a five-cycle d-miss fires when the miss clears
        do_reset();
        s = '0; s.mp = 1; s.dc = 1;
        repeat (5) step(s);
        s.dc = 0;
        step(s);
        step(s);
        step('0);

        // watchdog: three misses stay quiet, four set the sticky flag
        do_reset();
        s = '0; s.dc = 1;
        repeat (3) step(s);
        step('0);
        repeat (4) step(s);
        repeat (3) step('0);
        do_reset();
        step('0);

        // randomized traffic with a level-held mispredict
        mp_hold = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            s = rand_stim();
            if ($urandom_range(0, 3) == 0) mp_hold = !mp_hold;
            s.mp = mp_hold;
            step(s);
        end

        wait_cycles = 0;
        while (q.size() > 0 && wait_cycles < 5) begin
            @(posedge clk);
            wait_cycles++;
        end
        n_checks++;
        if (q.size() > 0) begin
            n_fail++;
            $display("FAIL drain got=%0d pending expected=0", q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
